// File: rtl/can_defs.sv
`default_nettype none
// ============================================================================
// Package     : can_defs
// Description : Shared CAN frame constants, state encoding and length helpers
// Revision    : 1.0 - initial release
// ============================================================================
package can_defs;

  localparam int ID_BASE_W = 11;
  localparam int ID_EXT_W  = 18;
  localparam int DLC_W     = 4;
  localparam int CRC_W     = 15;
  localparam int EOF_W     = 7;
  localparam int IFS_W     = 3;

  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  localparam int STD_BASE_LEN = 44;
  localparam int EXT_BASE_LEN = 64;

  // ARB holds ID/SRR/IDE/RTR; CTRL is IDE|r1, r0, DLC in both formats
  localparam int STD_ARB_W = ID_BASE_W + 1;
  localparam int EXT_ARB_W = ID_BASE_W + 2 + ID_EXT_W + 1;
  localparam int CTRL_W    = 2 + DLC_W;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SOF      = 4'd1,
    ST_ARB      = 4'd2,
    ST_CTRL     = 4'd3,
    ST_DATA     = 4'd4,
    ST_CRC      = 4'd5,
    ST_CRC_DEL  = 4'd6,
    ST_ACK_SLOT = 4'd7,
    ST_ACK_DEL  = 4'd8,
    ST_EOF      = 4'd9,
    ST_IFS      = 4'd10
  } can_state_e;

  function automatic logic [3:0] payload_bytes(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    if (dlc > 4'd8) return 4'd8;
    return dlc;
  endfunction

  function automatic logic [7:0] frame_len(input logic ide, input logic rtr, input logic [3:0] dlc);
    return (ide ? 8'(EXT_BASE_LEN) : 8'(STD_BASE_LEN)) + {1'b0, payload_bytes(rtr, dlc), 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// ============================================================================
// Module      : can_crc15
// Description : Serial CAN CRC-15 accumulator with clear and enable
// Revision    : 1.0 - initial release
// ============================================================================
module can_crc15
  import can_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_i ^ crc_q[CRC_W-1];
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/can_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : can_tx_frame_serializer
// Description : CAN 2.0A/B transmit serializer with stuffing, CRC-15, ARB/ACK
// Revision    : 1.0 - initial release
// ============================================================================
module can_tx_frame_serializer
  import can_defs::*;
#(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_start,
  input  logic [28:0] tx_id,
  input  logic        tx_ide,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        can_rx,
  output logic        can_tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_ack_err,
  output logic        tx_arb_lost,
  output logic [7:0]  frame_length_bits
);

  localparam int BIT_CLKS  = clk_speed_MHz * 1000 / can_bit_rate_Kbits;
  localparam int SAMPLE_PT = BIT_CLKS * 7 / 10;
  localparam int CNT_W     = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);

  can_state_e       state_q, state_d, adv_state;
  logic [5:0]       fld_q, fld_d, adv_fld;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_q, tx_d, stuff_q, stuff_d, last_q, last_d;
  logic [2:0]       run_q, run_d, run_new;
  logic [31:0]      arb_q, arb_d;
  logic             ide_q, ide_d;
  logic [3:0]       dlc_q, dlc_d, nbytes_q, nbytes_d;
  logic [63:0]      data_q, data_d;
  logic [7:0]       len_q, len_d;
  logic             ack_err_q, ack_err_d, done_q, done_d;
  logic             ack_pulse_q, ack_pulse_d, arb_lost_q, arb_lost_d;
  logic             frame_end, fld_bit, crc_clr, crc_en, in_crc, in_stuff, bit_end;
  logic [CRC_W-1:0] crc;
  logic [5:0]       arb_last, data_last;
  logic [7:0]       ctrl_vec;
  logic [CRC_W:0]   crc_ext;

  can_crc15 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (tx_q),
    .crc_o (crc)
  );

  assign bit_end   = (cnt_q == CNT_LAST);
  assign in_crc    = state_q inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA};
  assign in_stuff  = in_crc || (state_q == ST_CRC);
  assign run_new   = (run_q != 3'd0 && tx_q == last_q) ? run_q + 3'd1 : 3'd1;
  assign arb_last  = ide_q ? 6'(EXT_ARB_W - 1) : 6'(STD_ARB_W - 1);
  assign data_last = {nbytes_q[2:0] - 3'd1, 3'b111};
  assign ctrl_vec  = {2'b00, dlc_q, 2'b00};
  assign crc_ext   = {crc, 1'b0};

  // Position of the next unstuffed bit; state/field track the last data-carrying bit
  always_comb begin
    adv_state = state_q;
    adv_fld   = fld_q + 6'd1;
    frame_end = 1'b0;
    case (state_q)
      ST_SOF:      begin adv_state = ST_ARB; adv_fld = '0; end
      ST_ARB:      if (fld_q == arb_last) begin adv_state = ST_CTRL; adv_fld = '0; end
      ST_CTRL:     if (fld_q == 6'(CTRL_W - 1)) begin
                     adv_state = (nbytes_q == 4'd0) ? ST_CRC : ST_DATA;
                     adv_fld   = '0;
                   end
      ST_DATA:     if (fld_q == data_last) begin adv_state = ST_CRC; adv_fld = '0; end
      ST_CRC:      if (fld_q == 6'(CRC_W - 1)) begin adv_state = ST_CRC_DEL; adv_fld = '0; end
      ST_CRC_DEL:  begin adv_state = ST_ACK_SLOT; adv_fld = '0; end
      ST_ACK_SLOT: begin adv_state = ST_ACK_DEL; adv_fld = '0; end
      ST_ACK_DEL:  begin adv_state = ST_EOF; adv_fld = '0; end
      ST_EOF:      if (fld_q == 6'(EOF_W - 1)) begin adv_state = ST_IFS; adv_fld = '0; end
      ST_IFS:      if (fld_q == 6'(IFS_W - 1)) begin
                     adv_state = ST_IDLE;
                     adv_fld   = '0;
                     frame_end = 1'b1;
                   end
      default:     begin adv_state = ST_IDLE; adv_fld = '0; end
    endcase
  end

  always_comb begin
    fld_bit = 1'b1;
    case (adv_state)
      ST_SOF:  fld_bit = 1'b0;
      ST_ARB:  fld_bit = arb_q[~adv_fld[4:0]];
      ST_CTRL: fld_bit = ctrl_vec[~adv_fld[2:0]];
      ST_DATA: fld_bit = data_q[~adv_fld];
      ST_CRC:  fld_bit = crc_ext[~adv_fld[3:0]];
      default: fld_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fld_d       = fld_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    stuff_d     = stuff_q;
    run_d       = run_q;
    last_d      = last_q;
    arb_d       = arb_q;
    ide_d       = ide_q;
    dlc_d       = dlc_q;
    nbytes_d    = nbytes_q;
    data_d      = data_q;
    len_d       = len_q;
    ack_err_d   = ack_err_q;
    done_d      = 1'b0;
    ack_pulse_d = 1'b0;
    arb_lost_d  = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      tx_d  = 1'b1;
      if (tx_start) begin
        state_d   = ST_SOF;
        fld_d     = '0;
        tx_d      = 1'b0;
        stuff_d   = 1'b0;
        run_d     = '0;
        last_d    = 1'b0;
        ack_err_d = 1'b0;
        crc_clr   = 1'b1;
        arb_d     = tx_ide ? {tx_id[28:18], 1'b1, 1'b1, tx_id[17:0], tx_rtr}
                           : {tx_id[28:18], tx_rtr, 20'd0};
        ide_d     = tx_ide;
        dlc_d     = tx_dlc;
        nbytes_d  = payload_bytes(tx_rtr, tx_dlc);
        data_d    = tx_data;
        len_d     = frame_len(tx_ide, tx_rtr, tx_dlc);
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_SAMPLE) begin
        crc_en = in_crc && !stuff_q;
        if (state_q == ST_ACK_SLOT && can_rx) ack_err_d = 1'b1;
      end
      if (bit_end) begin
        if (in_stuff) begin
          run_d  = run_new;
          last_d = tx_q;
        end
        if (in_stuff && run_new == 3'd5) begin
          tx_d    = ~tx_q;
          stuff_d = 1'b1;
        end else begin
          stuff_d = 1'b0;
          state_d = adv_state;
          fld_d   = adv_fld;
          tx_d    = fld_bit;
          if (frame_end) begin
            done_d      = !ack_err_q;
            ack_pulse_d = ack_err_q;
          end
        end
      end
      if (cnt_q == CNT_SAMPLE && state_q == ST_ARB && !stuff_q && tx_q && !can_rx) begin
        state_d    = ST_IDLE;
        tx_d       = 1'b1;
        cnt_d      = '0;
        arb_lost_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fld_q       <= '0;
      cnt_q       <= '0;
      tx_q        <= 1'b1;
      stuff_q     <= 1'b0;
      run_q       <= '0;
      last_q      <= 1'b0;
      arb_q       <= '0;
      ide_q       <= 1'b0;
      dlc_q       <= '0;
      nbytes_q    <= '0;
      data_q      <= '0;
      len_q       <= '0;
      ack_err_q   <= 1'b0;
      done_q      <= 1'b0;
      ack_pulse_q <= 1'b0;
      arb_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fld_q       <= fld_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      stuff_q     <= stuff_d;
      run_q       <= run_d;
      last_q      <= last_d;
      arb_q       <= arb_d;
      ide_q       <= ide_d;
      dlc_q       <= dlc_d;
      nbytes_q    <= nbytes_d;
      data_q      <= data_d;
      len_q       <= len_d;
      ack_err_q   <= ack_err_d;
      done_q      <= done_d;
      ack_pulse_q <= ack_pulse_d;
      arb_lost_q  <= arb_lost_d;
    end
  end

  assign can_tx            = tx_q;
  assign tx_busy           = (state_q != ST_IDLE);
  assign tx_done           = done_q;
  assign tx_ack_err        = ack_pulse_q;
  assign tx_arb_lost       = arb_lost_q;
  assign frame_length_bits = len_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_tx_frame_serializer
// Description : Self-checking bench for the CAN transmit serializer
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_tx_frame_serializer;

  localparam int BIT_CLKS = 10;

  logic        clk = 1'b0;
  logic        rst, tx_start, tx_ide, tx_rtr, can_rx, can_tx;
  logic [28:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_busy, tx_done, tx_ack_err, tx_arb_lost;
  logic [7:0]  frame_length_bits;
  logic        rx_ovr, rx_val;

  int errors = 0, checks = 0;
  int n_done = 0, n_ackerr = 0, n_arb = 0;

  bit exp_q[$];
  int pos_q[$];
  int ack_idx, model_len, data_start;

  assign can_rx = rx_ovr ? rx_val : can_tx;

  can_tx_frame_serializer #(
    .clk_speed_MHz      (10),
    .can_bit_rate_Kbits (1000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tx_start          (tx_start),
    .tx_id             (tx_id),
    .tx_ide            (tx_ide),
    .tx_rtr            (tx_rtr),
    .tx_dlc            (tx_dlc),
    .tx_data           (tx_data),
    .can_rx            (can_rx),
    .can_tx            (can_tx),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_ack_err        (tx_ack_err),
    .tx_arb_lost       (tx_arb_lost),
    .frame_length_bits (frame_length_bits)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done)     n_done   <= n_done + 1;
    if (tx_ack_err)  n_ackerr <= n_ackerr + 1;
    if (tx_arb_lost) n_arb    <= n_arb + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: field list, CRC by polynomial long division, then stuffing
  function automatic void build(input logic [28:0] id, input logic ide, input logic rtr,
                                input logic [3:0] dlc, input logic [63:0] data);
    bit u[$];
    bit w[$];
    logic [15:0] g;
    int n, m, L, run;
    bit prev;
    g = 16'hC599;
    exp_q.delete();
    pos_q.delete();
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    u.push_back(1'b0);
    for (int i = 28; i >= 18; i--) u.push_back(id[i]);
    if (ide) begin
      u.push_back(1'b1);
      u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
    end
    u.push_back(rtr);
    u.push_back(1'b0);
    u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    data_start = u.size();
    for (int b = 0; b < 8 * n; b++) u.push_back(data[63 - b]);
    m = u.size();
    w = u;
    for (int i = 0; i < 15; i++) w.push_back(1'b0);
    for (int i = 0; i < m; i++)
      if (w[i]) for (int j = 0; j < 16; j++) w[i + j] = w[i + j] ^ g[15 - j];
    for (int i = 0; i < 15; i++) u.push_back(w[m + i]);
    L = u.size();
    for (int i = 0; i < 13; i++) u.push_back(1'b1);
    model_len = L + 10;
    run = 0;
    prev = 1'b0;
    for (int i = 0; i < u.size(); i++) begin
      exp_q.push_back(u[i]);
      pos_q.push_back(i);
      if (i < L) begin
        run  = (run > 0 && u[i] == prev) ? run + 1 : 1;
        prev = u[i];
        if (run == 5) begin
          exp_q.push_back(!prev);
          pos_q.push_back(-1);
          prev = !prev;
          run  = 1;
        end
      end
    end
    ack_idx = -1;
    for (int i = 0; i < pos_q.size(); i++) if (pos_q[i] == L + 1) ack_idx = i;
  endfunction

  // mode 0: ACK given, 1: ACK missing, 2: arbitration loss at 3rd ID bit, 3: reset mid-DATA
  task automatic run_frame(input string tag, input logic [28:0] id, input logic ide,
                           input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                           input int mode, input int exp_len);
    int d0, a0, l0, mism, first_bad, busy_bad, quiet_bad;
    build(id, ide, rtr, dlc, data);
    d0 = n_done; a0 = n_ackerr; l0 = n_arb;
    mism = 0; first_bad = -1; busy_bad = 0; quiet_bad = 0;
    tx_id = id; tx_ide = ide; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check({tag, "_len_model"}, 64'(frame_length_bits), 64'(model_len));
    if (exp_len > 0) check({tag, "_len_golden"}, 64'(frame_length_bits), 64'(exp_len));
    for (int i = 0; i < exp_q.size(); i++) begin
      rx_ovr = 1'b0;
      rx_val = 1'b1;
      if (mode != 1 && i == ack_idx) begin rx_ovr = 1'b1; rx_val = 1'b0; end
      if (mode == 2 && pos_q[i] == 3) begin
        rx_ovr = 1'b1;
        rx_val = 1'b0;
        check({tag, "_tx_before_loss"}, 64'(can_tx), 64'd1);
        for (int c = 0; c < 8; c++) step();
        rx_ovr = 1'b0;
        check({tag, "_arb_lost_pulse"}, 64'(tx_arb_lost), 64'd1);
        check({tag, "_tx_recessive"}, 64'(can_tx), 64'd1);
        check({tag, "_busy_dropped"}, 64'(tx_busy), 64'd0);
        step();
        check({tag, "_arb_lost_single"}, 64'(tx_arb_lost), 64'd0);
        for (int c = 0; c < 40; c++) step();
        check({tag, "_no_done"}, 64'(n_done - d0), 64'd0);
        check({tag, "_arb_count"}, 64'(n_arb - l0), 64'd1);
        return;
      end
      if (mode == 3 && pos_q[i] == data_start + 4) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({tag, "_post_reset_outputs"},
              64'({can_tx, tx_busy, tx_done, tx_ack_err, tx_arb_lost, frame_length_bits}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}));
        for (int c = 0; c < 300; c++) begin
          step();
          if (can_tx !== 1'b1 || tx_busy !== 1'b0) quiet_bad++;
        end
        check({tag, "_quiet_after_reset"}, 64'(quiet_bad), 64'd0);
        check({tag, "_no_pulses"}, 64'((n_done - d0) + (n_ackerr - a0) + (n_arb - l0)), 64'd0);
        return;
      end
      if (can_tx !== exp_q[i]) begin
        mism++;
        if (first_bad < 0) first_bad = i;
      end
      if (tx_busy !== 1'b1) busy_bad++;
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (i == 6 && c == 2) begin
          tx_id    = 29'($urandom);
          tx_ide   = ~ide;
          tx_rtr   = ~rtr;
          tx_dlc   = 4'($urandom);
          tx_data  = {$urandom, $urandom};
          tx_start = 1'b1;
        end
        step();
        tx_start = 1'b0;
      end
    end
    rx_ovr = 1'b0;
    check({tag, "_stream_mismatches"}, 64'(mism), 64'd0);
    if (mism != 0) $display("  %s first differing bit index %0d", tag, first_bad);
    check({tag, "_busy_during_frame"}, 64'(busy_bad), 64'd0);
    check({tag, "_end_busy_done_ackerr"}, 64'({tx_busy, tx_done, tx_ack_err}),
          (mode == 1) ? 64'b001 : 64'b010);
    step();
    step();
    check({tag, "_done_count"}, 64'(n_done - d0), (mode == 1) ? 64'd0 : 64'd1);
    check({tag, "_ackerr_count"}, 64'(n_ackerr - a0), (mode == 1) ? 64'd1 : 64'd0);
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_id = '0; tx_ide = 1'b0; tx_rtr = 1'b0;
    tx_dlc = '0; tx_data = '0; rx_ovr = 1'b0; rx_val = 1'b1;
    step(); step(); step();
    check("reset_can_tx", 64'(can_tx), 64'd1);
    check("reset_pulses_busy", 64'({tx_busy, tx_done, tx_ack_err, tx_arb_lost}), 64'd0);
    check("reset_len", 64'(frame_length_bits), 64'd0);
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check("reset_beats_start", 64'({tx_busy, can_tx}), 64'b01);
    rst = 1'b0;
    step();
    check("idle_after_reset", 64'({tx_busy, can_tx}), 64'b01);

    run_frame("std_data", {11'h123, 18'd0}, 1'b0, 1'b0, 4'd2, 64'hAA55_0000_0000_0000, 0, 60);
    run_frame("std_remote", {11'h7FF, 18'd0}, 1'b0, 1'b1, 4'd8, 64'h0123_4567_89AB_CDEF, 0, 44);
    run_frame("ext_dlc15", 29'h1ABCDEF0, 1'b1, 1'b0, 4'd15, 64'd0, 0, 128);
    for (int k = 0; k < 3; k++)
      run_frame($sformatf("rand%0d", k), 29'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                4'($urandom), {$urandom, $urandom}, 0, 0);
    run_frame("arb_loss", {11'h123, 18'd0}, 1'b0, 1'b0, 4'd1, 64'hFF00_0000_0000_0000, 2, 52);
    run_frame("ack_missing", 29'($urandom), 1'($urandom), 1'b0, 4'($urandom_range(0, 8)),
              {$urandom, $urandom}, 1, 0);
    run_frame("reset_mid_data", 29'($urandom), 1'b0, 1'b0, 4'd4, {$urandom, $urandom}, 3, 76);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
